// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan_display.
// The master drives the BCD/control inputs, and the slave drives the scan outputs.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 2
);
  logic [4*NUM_DIGITS-1:0] bcd_num;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lz;
  logic                    blink_en;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   cat;
  logic                    frame_start;

  modport master (
    output bcd_num, dp_mask, blank_lz, blink_en,
    input  seg, cat, frame_start
  );

  modport slave (
    input  bcd_num, dp_mask, blank_lz, blink_en,
    output seg, cat, frame_start
  );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed common-cathode 7-segment driver with frame shadowing,
// leading-zero blanking, decimal points, blink and a ghost guard cycle.
module seg_scan_display #(
  parameter int NUM_DIGITS   = 2,
  parameter int SCAN_DIV     = 4,
  parameter int GUARD        = 1,
  parameter int BLINK_FRAMES = 50
) (
  input  logic         clk,
  input  logic         rst,
  seg_scan_if.slave    io
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {PH_ON, PH_OFF} phase_e;

  logic [DW-1:0]           d_q, d_d;
  logic [KW-1:0]           k_q, k_d;
  logic [4*NUM_DIGITS-1:0] sh_bcd_q, sh_bcd_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    sh_lz_q, sh_lz_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  phase_e                  phase_q, phase_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   cat_q, cat_d;
  logic                    fs_q, fs_d;

  logic       d_wrap;
  logic       load;
  logic       hi_zero;
  logic       blank;
  logic       dp;
  logic [3:0] nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  always_comb begin
    d_wrap = (d_q == DW'(SCAN_DIV - 1));
    load   = d_wrap && (k_q == KW'(NUM_DIGITS - 1));
    d_d    = d_wrap ? '0 : d_q + DW'(1);
    k_d    = k_q;
    if (d_wrap)
      k_d = (k_q == KW'(NUM_DIGITS - 1)) ? '0 : k_q + KW'(1);

    sh_bcd_d = sh_bcd_q;
    sh_dp_d  = sh_dp_q;
    sh_lz_d  = sh_lz_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    if (load) begin
      sh_bcd_d = io.bcd_num;
      sh_dp_d  = io.dp_mask;
      sh_lz_d  = io.blank_lz;
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
    fs_d = load;

    // Walk from the top digit down so hi_zero covers "this and all higher".
    hi_zero = 1'b1;
    nib     = 4'd0;
    dp      = 1'b0;
    blank   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero && (sh_bcd_q[i*4 +: 4] == 4'd0);
      if (KW'(i) == k_q) begin
        nib   = sh_bcd_q[i*4 +: 4];
        dp    = sh_dp_q[i];
        blank = sh_lz_q && hi_zero && (i != 0);
      end
    end

    cat_d = '1;
    seg_d = 8'd0;
    if (!((GUARD != 0) && (d_q == '0))) begin
      cat_d = ~(NUM_DIGITS'(1) << k_q);
      seg_d = {blank ? 7'd0 : decode(nib), dp};
      if (io.blink_en && (phase_q == PH_OFF))
        seg_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q      <= '0;
      k_q      <= '0;
      sh_bcd_q <= '0;
      sh_dp_q  <= '0;
      sh_lz_q  <= 1'b0;
      bcnt_q   <= '0;
      phase_q  <= PH_ON;
      seg_q    <= 8'd0;
      cat_q    <= '1;
      fs_q     <= 1'b0;
    end else begin
      d_q      <= d_d;
      k_q      <= k_d;
      sh_bcd_q <= sh_bcd_d;
      sh_dp_q  <= sh_dp_d;
      sh_lz_q  <= sh_lz_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      cat_q    <= cat_d;
      fs_q     <= fs_d;
    end
  end

  assign io.seg         = seg_q;
  assign io.cat         = cat_q;
  assign io.frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (2 digits, dwell 4, guard on,
// two frames per blink half-period).
module tb_seg_scan_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  seg_scan_if #(.NUM_DIGITS(2)) bus ();

  seg_scan_display #(
    .NUM_DIGITS(2),
    .SCAN_DIV(4),
    .GUARD(1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  initial begin
    bus.bcd_num  = 8'h00;
    bus.dp_mask  = 2'b00;
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cat", 8'(bus.cat), 8'b11);
    chk("rst_seg", bus.seg, 8'h00);
    chk("rst_fs", 8'(bus.frame_start), 8'd0);
    rst = 1'b0;
    cyc = 0;

    run_to(1);
    chk("c1_cat", 8'(bus.cat), 8'b11);
    chk("c1_seg", bus.seg, 8'h00);
    for (int c = 2; c <= 4; c++) begin
      run_to(c);
      chk("d0_cat", 8'(bus.cat), 8'b10);
      chk("d0_seg", bus.seg, 8'b11111100);
    end
    run_to(5);
    chk("c5_guard", 8'(bus.cat), 8'b11);
    run_to(6);
    chk("c6_cat", 8'(bus.cat), 8'b01);
    chk("c6_seg", bus.seg, 8'b11111100);
    run_to(7);
    chk("c7_fs", 8'(bus.frame_start), 8'd0);
    run_to(8);
    chk("c8_fs", 8'(bus.frame_start), 8'd1);
    run_to(9);
    chk("c9_fs", 8'(bus.frame_start), 8'd0);

    run_to(10);
    bus.bcd_num = 8'h19;
    chk("f2_d0", bus.seg, 8'b11111100);
    run_to(14);
    chk("f2_d1", bus.seg, 8'b11111100);
    run_to(16);
    chk("c16_fs", 8'(bus.frame_start), 8'd1);
    run_to(18);
    chk("f3_d0_cat", 8'(bus.cat), 8'b10);
    chk("f3_d0", bus.seg, 8'b11110110);
    run_to(22);
    chk("f3_d1_cat", 8'(bus.cat), 8'b01);
    chk("f3_d1", bus.seg, 8'b01100000);

    bus.bcd_num  = 8'h07;
    bus.blank_lz = 1'b1;
    run_to(26);
    chk("lz_d0", bus.seg, 8'b11100000);
    run_to(30);
    chk("lz_d1_cat", 8'(bus.cat), 8'b01);
    chk("lz_d1", bus.seg, 8'h00);
    bus.blank_lz = 1'b0;
    run_to(34);
    chk("nolz_d0", bus.seg, 8'b11100000);
    run_to(38);
    chk("nolz_d1", bus.seg, 8'b11111100);

    bus.bcd_num = 8'h1A;
    bus.dp_mask = 2'b10;
    run_to(42);
    chk("inv_d0", bus.seg, 8'b00000010);
    run_to(46);
    chk("inv_d1", bus.seg, 8'b01100001);

    rst = 1'b1;
    #1;
    chk("arst_cat", 8'(bus.cat), 8'b11);
    chk("arst_seg", bus.seg, 8'h00);
    chk("arst_fs", 8'(bus.frame_start), 8'd0);

    @(negedge clk);
    bus.bcd_num  = 8'h19;
    bus.dp_mask  = 2'b00;
    bus.blink_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    run_to(2);
    chk("bk_f1", bus.seg, 8'b11111100);
    run_to(10);
    chk("bk_f2", bus.seg, 8'b11110110);
    run_to(18);
    chk("bk_f3_cat", 8'(bus.cat), 8'b10);
    chk("bk_f3_seg", bus.seg, 8'h00);
    run_to(30);
    chk("bk_f4_cat", 8'(bus.cat), 8'b01);
    chk("bk_f4_seg", bus.seg, 8'h00);
    run_to(34);
    chk("bk_f5", bus.seg, 8'b11110110);
    run_to(46);
    chk("bk_f6", bus.seg, 8'b01100000);
    run_to(50);
    chk("bk_f7", bus.seg, 8'h00);
    bus.blink_en = 1'b0;
    run_to(51);
    chk("bk_off", bus.seg, 8'b11110110);
    chk("bk_off_cat", 8'(bus.cat), 8'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
